midi_cmd_parser: RTL and testbench
==================================

Name: midi_cmd_parser

Overview:
Upstream stage of bank_manager_p. Parses a raw MIDI byte stream from the UART receiver into the 16-bit note command word that bank_manager_p samples on every clock: bit 15 = on/off, [14:8] = note, [7:0] = {1'b0, velocity}. Handles running status, real-time interleaving, channel filtering and All-Notes-Off. Emits each command as a single-cycle pulse, because the downstream block has no valid input and acts on every cycle.

Parameters:
CHANNEL, 0, MIDI channel accepted (0-15) when OMNI=0.
OMNI, 0, 1 = accept all channels.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
i_byte  in  8  received MIDI byte
i_byte_valid  in  1  i_byte valid this cycle (single-cycle strobe per byte)
o_data  out  16  command word to bank_manager_p i_data; 16'h0000 when idle
o_valid  out  1  high for the one cycle in which o_data carries a command
o_dropped  out  8  saturating count of discarded messages

Behaviour:
- Reset: single clock domain on clk. reset is synchronous and active-high; it overrides all other inputs. Reset values: o_data=0, o_valid=0, o_dropped=0, state=IDLE, running status cleared, captured bytes cleared.
- Idle output: o_data=16'h0000 on every cycle without a command. Downstream treats this as an off-command for note 0, which has no effect.
- Byte classes:
  - Status: bit7=1.
  - Data: bit7=0.
  - Real-time: 0xF8-0xFF.
  - System common/SysEx: 0xF0-0xF7.
- Real-time bytes are ignored with no state change and no loss of running status, including between the two data bytes of a message.
- System common/SysEx bytes clear running status and go to SKIP. SKIP discards data bytes until the next channel status byte.
- Channel status bytes 0x80-0xEF:
  - Latch as running status; go to WAIT_D1.
  - Type 0x8n/0x9n/0xBn with a matching channel is "accepted". All other types or channels are "ignored"; their data bytes are consumed with no output.
- States: IDLE, WAIT_D1, WAIT_D2, SKIP.
  - IDLE + data byte: running status valid -> treat as D1 and go to WAIT_D2; otherwise discard and stay in IDLE.
  - WAIT_D1 + data byte: capture note/controller; go to WAIT_D2.
  - WAIT_D2 + data byte: capture velocity/value; evaluate; go to WAIT_D1 (running status retained).
  - Any state + channel status byte: restart at WAIT_D1. A partial message is abandoned and o_dropped increments.
  - Program change 0xCn and channel pressure 0xDn are 1-data-byte messages. Their single data byte completes the message (return to WAIT_D1) with no output.
- Evaluation after D2, registered; o_valid and o_data appear the cycle after the D2 byte's i_byte_valid:
  - Note-on (0x9n) with vel!=0: o_data={1'b1, note, 1'b0, vel}.
  - Note-on with vel=0, or note-off (0x8n): o_data={1'b0, note, 8'h00}.
  - Notes 0 and 127 are reserved codes downstream ("empty slot" and STOP_ALL). Both are dropped, o_dropped++, no output.
  - Control change 0xBn, controller 123 (All Notes Off) or 120 (All Sound Off): o_data={1'b0, 7'h7F, 8'h00}. Other controllers produce no output.
- One command maximum per byte, so at most one pulse per i_byte_valid. o_valid is never high on two consecutive cycles unless i_byte_valid is high on consecutive cycles.
- o_dropped saturates at 255; it does not wrap.
- Reset mid-message: the partial message is lost, no output is produced, and running status is cleared.

Decomposition:
- Shared package midi_pkg:
  - status nibble constants: NOTE_OFF=4'h8, NOTE_ON=4'h9, CC=4'hB, PROG=4'hC, CHPRESS=4'hD
  - CC_ALL_NOTES_OFF=7'd123, CC_ALL_SOUND_OFF=7'd120
  - STOP_ALL_NOTE=7'h7F
  - state encoding.
- bank_manager_p decode of bit 15 / [14:8] uses the same constants.
- No sub-module; single FSM plus capture registers.

Test Plan:
1. Bytes 0x90,0x3C,0x64 -> one cycle after the last byte: o_valid=1, o_data=16'hBC64; next cycle o_data=16'h0000.
2. Running status: 0x90,0x40,0x50,0x40,0x00 -> pulses 16'hC050, then 16'h4000 (vel-0 note-off).
3. 0x90,0x3C,0xF8,0x64 -> the real-time byte is ignored; a single pulse 16'hBC64.
4. CHANNEL=0, OMNI=0: 0x91,0x3C,0x64 -> no pulse. Then 0xB0,0x7B,0x00 -> pulse 16'h7F00.
5. 0x90,0x7F,0x40 and 0x80,0x00,0x00 -> no pulses; o_dropped=2. Then 0x90,0x3C followed by 0x80 -> o_dropped=3, parser in WAIT_D1 under 0x80.
6. Assert reset between D1 and D2 of 0x90,0x3C,.. -> the following data byte 0x64 yields no pulse; o_dropped=0, o_data=0.

Source files
------------

// File: rtl/midi_pkg.sv
// Shared MIDI constants and parser state encoding.
// Used by the command parser and the bank manager decode.
package midi_pkg;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] CC       = 4'hB;
  localparam logic [3:0] PROG     = 4'hC;
  localparam logic [3:0] CHPRESS  = 4'hD;

  localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;
  localparam logic [6:0] CC_ALL_SOUND_OFF = 7'd120;
  localparam logic [6:0] STOP_ALL_NOTE    = 7'h7F;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_D1 = 2'd1,
    WAIT_D2 = 2'd2,
    SKIP    = 2'd3
  } state_t;

endpackage

// File: rtl/midi_cmd_parser.sv
// MIDI byte stream to single-cycle 16-bit note command pulses.
// Running status, real-time skipping, channel filter, all-notes-off.
module midi_cmd_parser
  import midi_pkg::*;
#(
  parameter int unsigned CHANNEL = 0,
  parameter bit          OMNI    = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  i_byte,
  input  logic        i_byte_valid,
  output logic [15:0] o_data,
  output logic        o_valid,
  output logic [7:0]  o_dropped
);

  state_t      state;
  logic [7:0]  rs;
  logic        rs_valid;
  logic [6:0]  d1;

  logic        is_rt;
  logic        is_sys;
  logic        is_stat;
  logic        is_data;
  logic [3:0]  rs_type;
  logic        ch_ok;
  logic        acc;
  logic        one_byte;
  logic [6:0]  dbyte;

  logic        ev_valid;
  logic [15:0] ev_data;
  logic        ev_drop;
  logic        drop_inc;

  assign is_rt   = &i_byte[7:3];
  assign is_sys  = (i_byte[7:3] == 5'b11110);
  assign is_stat = i_byte[7] && (i_byte[7:4] != 4'hF);
  assign is_data = !i_byte[7];
  assign dbyte   = i_byte[6:0];

  assign rs_type  = rs[7:4];
  assign ch_ok    = OMNI || (rs[3:0] == 4'(CHANNEL));
  assign one_byte = (rs_type == PROG) || (rs_type == CHPRESS);
  assign acc      = ch_ok && ((rs_type == NOTE_OFF) ||
                              (rs_type == NOTE_ON)  ||
                              (rs_type == CC));

  // Outcome of a message completed by the current data byte
  always_comb begin
    ev_valid = 1'b0;
    ev_data  = '0;
    ev_drop  = 1'b0;
    if (acc) begin
      unique case (rs_type)
        NOTE_ON, NOTE_OFF: begin
          if (d1 == 7'h00 || d1 == STOP_ALL_NOTE) begin
            ev_drop = 1'b1;
          end else if (rs_type == NOTE_ON && dbyte != 7'h00) begin
            ev_valid = 1'b1;
            ev_data  = {1'b1, d1, 1'b0, dbyte};
          end else begin
            ev_valid = 1'b1;
            ev_data  = {1'b0, d1, 8'h00};
          end
        end
        CC: begin
          if (d1 == CC_ALL_NOTES_OFF || d1 == CC_ALL_SOUND_OFF) begin
            ev_valid = 1'b1;
            ev_data  = {1'b0, STOP_ALL_NOTE, 8'h00};
          end
        end
        default: ;
      endcase
    end
  end

  // A status byte arriving in WAIT_D2 abandons a half-received message
  assign drop_inc = i_byte_valid && (state == WAIT_D2) &&
                    (is_stat || (is_data && ev_drop));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rs        <= '0;
      rs_valid  <= 1'b0;
      d1        <= '0;
      o_data    <= '0;
      o_valid   <= 1'b0;
      o_dropped <= '0;
    end else begin
      o_valid <= 1'b0;
      o_data  <= '0;
      if (drop_inc && o_dropped != 8'hFF) begin
        o_dropped <= o_dropped + 8'd1;
      end
      if (i_byte_valid) begin
        unique case (1'b1)
          is_rt: ;
          is_sys: begin
            state    <= SKIP;
            rs_valid <= 1'b0;
          end
          is_stat: begin
            rs       <= i_byte;
            rs_valid <= 1'b1;
            state    <= WAIT_D1;
          end
          is_data: begin
            unique case (state)
              IDLE, WAIT_D1: begin
                if (state == WAIT_D1 || rs_valid) begin
                  if (one_byte) begin
                    state <= WAIT_D1;
                  end else begin
                    d1    <= dbyte;
                    state <= WAIT_D2;
                  end
                end
              end
              WAIT_D2: begin
                o_valid <= ev_valid;
                o_data  <= ev_data;
                state   <= WAIT_D1;
              end
              SKIP: ;
            endcase
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_midi_cmd_parser.sv
// Scoreboard bench for midi_cmd_parser with a message-level
// reference model, directed scenarios and random byte streams.
module tb_midi_cmd_parser;

  localparam int unsigned CH   = 0;
  localparam bit          OMNI = 1'b0;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  i_byte;
  logic        i_byte_valid;
  logic [15:0] o_data;
  logic        o_valid;
  logic [7:0]  o_dropped;

  midi_cmd_parser #(.CHANNEL(CH), .OMNI(OMNI)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_byte       (i_byte),
    .i_byte_valid (i_byte_valid),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .o_dropped    (o_dropped)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];
  int          m_rs = -1;
  int          m_pend[$];
  int          exp_dropped = 0;
  int          drop_snap = 0;
  bit          mon_en = 1'b0;
  int          npulses = 0;
  logic [15:0] last_pulse = '0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic int need(input int s);
    int t;
    t = s >> 4;
    return (t == 12 || t == 13) ? 1 : 2;
  endfunction

  function automatic void bump();
    if (exp_dropped < 255) exp_dropped++;
  endfunction

  function automatic void evaluate();
    int t, ch, note, v;
    t  = m_rs >> 4;
    ch = m_rs & 15;
    if (!(OMNI || ch == int'(CH))) return;
    note = m_pend[0];
    v    = (m_pend.size() > 1) ? m_pend[1] : 0;
    if (t == 8 || t == 9) begin
      if (note == 0 || note == 127) bump();
      else if (t == 9 && v != 0)
        exp_q.push_back(16'(32768 + note * 256 + v));
      else
        exp_q.push_back(16'(note * 256));
    end else if (t == 11 && (note == 123 || note == 120)) begin
      exp_q.push_back(16'h7F00);
    end
  endfunction

  function automatic void model_byte(input int b);
    if (b >= 'hF8) return;
    if (b >= 'hF0) begin
      m_rs = -1;
      m_pend.delete();
      return;
    end
    if (b >= 'h80) begin
      if (m_pend.size() > 0) bump();
      m_rs = b;
      m_pend.delete();
      return;
    end
    if (m_rs < 0) return;
    m_pend.push_back(b);
    if (m_pend.size() == need(m_rs)) begin
      evaluate();
      m_pend.delete();
    end
  endfunction

  // Called at posedge+1; the byte is consumed at the next posedge
  task automatic send(input logic [7:0] b, input int gap);
    i_byte       = b;
    i_byte_valid = 1'b1;
    model_byte(int'(b));
    @(posedge clk); #1;
    i_byte_valid = 1'b0;
    i_byte       = '0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c);
    send(a, 0);
    send(b, 0);
    send(c, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m_rs  = -1;
    m_pend.delete();
    exp_dropped = 0;
    idle(2);
    reset = 1'b0;
  endtask

  always @(posedge clk) drop_snap = exp_dropped;

  // Monitor: every pulse pops one expected word
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (o_valid) begin
        npulses++;
        last_pulse = o_data;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse got=%h expected=none", o_data);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          if (o_data !== e) begin
            errors++;
            $display("FAIL pulse_data got=%h expected=%h", o_data, e);
          end
        end
      end else if (o_data !== 16'h0000) begin
        errors++;
        $display("FAIL idle_data got=%h expected=0000", o_data);
      end
      checks++;
      if (int'(o_dropped) != drop_snap) begin
        errors++;
        $display("FAIL dropped got=%0d expected=%0d", o_dropped, drop_snap);
      end
    end
  end

  initial begin
    int p0;
    int r, gap;
    logic [7:0] b;
    reset        = 1'b1;
    i_byte       = '0;
    i_byte_valid = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    idle(1);
    reset = 1'b0;
    chk("reset_data", int'(o_data), 0);
    chk("reset_valid", int'(o_valid), 0);
    chk("reset_dropped", int'(o_dropped), 0);

    p0 = npulses;
    send3(8'h90, 8'h3C, 8'h64);
    @(negedge clk);
    chk("t1_pulse_now", int'(o_valid), 1);
    chk("t1_data", int'(o_data), 'hBC64);
    @(negedge clk);
    chk("t1_idle_after", int'(o_data), 0);
    #1;
    chk("t1_count", npulses - p0, 1);

    p0 = npulses;
    send(8'h90, 1);
    send(8'h40, 0);
    send(8'h50, 0);
    send(8'h40, 2);
    send(8'h00, 0);
    idle(3);
    chk("t2_count", npulses - p0, 2);
    chk("t2_last", int'(last_pulse), 'h4000);

    p0 = npulses;
    send(8'h90, 0);
    send(8'h3C, 0);
    send(8'hF8, 0);
    send(8'h64, 0);
    idle(3);
    chk("t3_count", npulses - p0, 1);
    chk("t3_last", int'(last_pulse), 'hBC64);

    p0 = npulses;
    send3(8'h91, 8'h3C, 8'h64);
    idle(3);
    chk("t4_filtered", npulses - p0, 0);
    send3(8'hB0, 8'h7B, 8'h00);
    idle(3);
    chk("t4_ano_count", npulses - p0, 1);
    chk("t4_ano_data", int'(last_pulse), 'h7F00);

    do_reset();
    p0 = npulses;
    send3(8'h90, 8'h7F, 8'h40);
    send3(8'h80, 8'h00, 8'h00);
    idle(2);
    chk("t5_drop2", int'(o_dropped), 2);
    send(8'h90, 0);
    send(8'h3C, 0);
    send(8'h80, 0);
    idle(2);
    chk("t5_drop3", int'(o_dropped), 3);
    chk("t5_nopulse", npulses - p0, 0);
    send(8'h3C, 0);
    send(8'h40, 0);
    idle(3);
    chk("t5_rs_80", int'(last_pulse), 'h3C00);

    p0 = npulses;
    send(8'h90, 0);
    send(8'h3C, 0);
    do_reset();
    send(8'h64, 0);
    idle(3);
    chk("t6_nopulse", npulses - p0, 0);
    chk("t6_dropped", int'(o_dropped), 0);
    chk("t6_data", int'(o_data), 0);

    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 55) begin
        if (r < 5) b = 8'h00;
        else if (r < 8) b = 8'h7F;
        else if (r < 10) b = 8'd123;
        else if (r < 12) b = 8'd120;
        else b = 8'($urandom_range(0, 127));
      end else if (r < 85) begin
        case ($urandom_range(0, 6))
          0: b[7:4] = 4'h8;
          1: b[7:4] = 4'h9;
          2: b[7:4] = 4'hB;
          3: b[7:4] = 4'hC;
          4: b[7:4] = 4'hD;
          5: b[7:4] = 4'hA;
          default: b[7:4] = 4'hE;
        endcase
        if ($urandom_range(0, 9) == 0) b[3:0] = 4'($urandom_range(0, 15));
        else b[3:0] = 4'($urandom_range(0, 1));
      end else if (r < 93) begin
        b = 8'hF8 + 8'($urandom_range(0, 7));
      end else begin
        b = 8'hF0 + 8'($urandom_range(0, 7));
      end
      gap = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 2);
      send(b, gap);
    end
    idle(4);
    chk("rand_queue_empty", exp_q.size(), 0);

    do_reset();
    send(8'h90, 0);
    for (int i = 0; i < 270; i++) begin
      send(8'h00, 0);
      send(8'h40, 0);
    end
    idle(2);
    chk("sat_dropped", int'(o_dropped), 255);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
